clock_enable_divider_multi: RTL and testbench

Multi-channel, run-time programmable clock-enable divider. It divides one upstream clock enable, `i_ce_mhz`, into `par_channels` independent strobes, each with its own divisor and phase offset, plus a square-wave output per channel. Divisor and phase changes are double-buffered so that no channel produces a short or merged period. A sync input realigns all channels. It sits beside the single-clock system timing logic and feeds the LED, UART and sampling schedulers.

---
 rtl/clock_enable_divider_multi_if.sv | 27 ++
 rtl/clock_enable_divider_multi.sv | 73 +++++++
 tb/tb_clock_enable_divider_multi.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/clock_enable_divider_multi_if.sv
// clock_enable_divider_multi_if: control inputs, config bus and strobe outputs of the divider.
interface clock_enable_divider_multi_if #(
    parameter int par_channels  = 4,
    parameter int par_cnt_width = 16
);
    localparam int ch_w = (par_channels > 1) ? $clog2(par_channels) : 1;

    logic                     i_ce_mhz;
    logic                     i_sync;
    logic                     i_cfg_wr;
    logic [ch_w-1:0]          i_cfg_ch;
    logic [par_cnt_width-1:0] i_cfg_divisor;
    logic [par_cnt_width-1:0] i_cfg_phase;
    logic [par_channels-1:0]  o_ce_div;
    logic [par_channels-1:0]  o_sq_div;
    logic [par_channels-1:0]  o_cfg_pending;

    modport master (
        output i_ce_mhz, i_sync, i_cfg_wr, i_cfg_ch, i_cfg_divisor, i_cfg_phase,
        input  o_ce_div, o_sq_div, o_cfg_pending
    );

    modport slave (
        input  i_ce_mhz, i_sync, i_cfg_wr, i_cfg_ch, i_cfg_divisor, i_cfg_phase,
        output o_ce_div, o_sq_div, o_cfg_pending
    );
endinterface

// File: rtl/clock_enable_divider_multi.sv
// clock_enable_divider_multi: per-channel programmable clock-enable divider with double-buffered config.
module clock_enable_divider_multi #(
    parameter int par_channels        = 4,
    parameter int par_cnt_width       = 16,
    parameter int par_default_divisor = 1000
) (
    input logic                         i_clk_mhz,
    input logic                         i_rst_mhz_n,
    clock_enable_divider_multi_if.slave bus
);
    localparam int ch_w = (par_channels > 1) ? $clog2(par_channels) : 1;
    localparam logic [par_cnt_width-1:0] def_div = par_cnt_width'(par_default_divisor);

    for (genvar k = 0; k < par_channels; k++) begin : g_ch
        logic [par_cnt_width-1:0] div_q, div_d, ph_q, ph_d;
        logic [par_cnt_width-1:0] sdiv_q, sdiv_d, sph_q, sph_d;
        logic [par_cnt_width-1:0] cnt_q, cnt_d;
        logic                     ce_q, ce_d, sq_q, sq_d, pend_q, pend_d;
        logic                     wr_hit, term, stopped, apply;
        // An index equal to k is always in range, so out-of-range writes match no channel.
        // Next state: sync beats stop, stop beats counting; shadow applies at terminal, when stopped, or on sync.
        always_comb begin
            wr_hit  = bus.i_cfg_wr && (bus.i_cfg_ch == ch_w'(k));
            stopped = (div_q == '0);
            term    = !stopped && (cnt_q == div_q - 1'b1);
            apply   = pend_q && (bus.i_sync || stopped || (bus.i_ce_mhz && term));
            div_d   = apply ? sdiv_q : div_q;
            ph_d    = apply ? ((sph_q >= sdiv_q) ? '0 : sph_q) : ph_q;
            sdiv_d  = wr_hit ? bus.i_cfg_divisor : sdiv_q;
            sph_d   = wr_hit ? bus.i_cfg_phase : sph_q;
            pend_d  = wr_hit || (pend_q && !apply);
            cnt_d   = cnt_q;
            ce_d    = 1'b0;
            sq_d    = sq_q;
            if (bus.i_sync) begin
                cnt_d = ph_d;
                sq_d  = 1'b0;
            end else if (stopped) begin
                cnt_d = apply ? ph_d : '0;
                sq_d  = 1'b0;
            end else if (bus.i_ce_mhz) begin
                cnt_d = term ? (apply ? ph_d : '0) : cnt_q + 1'b1;
                ce_d  = term;
                sq_d  = sq_q ^ term;
            end
        end
        // Channel state registers with asynchronous reset to the default divisor.
        always_ff @(posedge i_clk_mhz or negedge i_rst_mhz_n) begin
            if (!i_rst_mhz_n) begin
                div_q  <= def_div;
                sdiv_q <= def_div;
                ph_q   <= '0;
                sph_q  <= '0;
                cnt_q  <= '0;
                ce_q   <= 1'b0;
                sq_q   <= 1'b0;
                pend_q <= 1'b0;
            end else begin
                div_q  <= div_d;
                sdiv_q <= sdiv_d;
                ph_q   <= ph_d;
                sph_q  <= sph_d;
                cnt_q  <= cnt_d;
                ce_q   <= ce_d;
                sq_q   <= sq_d;
                pend_q <= pend_d;
            end
        end
        assign bus.o_ce_div[k]      = ce_q;
        assign bus.o_sq_div[k]      = sq_q;
        assign bus.o_cfg_pending[k] = pend_q;
    end
endmodule

// File: tb/tb_clock_enable_divider_multi.sv
// tb_clock_enable_divider_multi: directed checks of strobe timing, config buffering, sync and reset.
module tb_clock_enable_divider_multi;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    clock_enable_divider_multi_if #(.par_channels(5), .par_cnt_width(16)) bus ();

    clock_enable_divider_multi #(
        .par_channels(5),
        .par_cnt_width(16),
        .par_default_divisor(5)
    ) dut (
        .i_clk_mhz  (clk),
        .i_rst_mhz_n(rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.i_ce_mhz = 1'b0;
        bus.i_sync   = 1'b0;
        bus.i_cfg_wr = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
    endtask

    task automatic cfg(input int ch, input int d, input int p);
        bus.i_cfg_wr      = 1'b1;
        bus.i_cfg_ch      = 3'(ch);
        bus.i_cfg_divisor = 16'(d);
        bus.i_cfg_phase   = 16'(p);
        cyc();
        bus.i_cfg_wr = 1'b0;
    endtask

    task automatic sync_pulse();
        bus.i_sync = 1'b1;
        cyc();
        bus.i_sync = 1'b0;
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.i_ce_mhz      = 1'b0;
        bus.i_sync        = 1'b0;
        bus.i_cfg_wr      = 1'b0;
        bus.i_cfg_ch      = '0;
        bus.i_cfg_divisor = '0;
        bus.i_cfg_phase   = '0;
        repeat (2) cyc();
        check("rst_ce", 32'(bus.o_ce_div), 0);
        check("rst_sq", 32'(bus.o_sq_div), 0);
        check("rst_pend", 32'(bus.o_cfg_pending), 0);

        // Default divisor 5, enable always on: strobe after every 5th tick.
        rst_n        = 1'b1;
        bus.i_ce_mhz = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            cyc();
            check($sformatf("p1_ce%0d", n), 32'(bus.o_ce_div), (n % 5 == 0) ? 32'h1f : 0);
            check($sformatf("p1_sq%0d", n), 32'(bus.o_sq_div), ((n / 5) % 2 == 1) ? 32'h1f : 0);
        end

        // Channel 1 D=4 P=3, then sync realigns everyone.
        cfg(1, 4, 3);
        check("p2_pend", 32'(bus.o_cfg_pending), 32'h02);
        sync_pulse();
        check("p2_sync_ce", 32'(bus.o_ce_div), 0);
        check("p2_sync_sq", 32'(bus.o_sq_div), 0);
        check("p2_sync_pend", 32'(bus.o_cfg_pending), 0);
        for (int m = 1; m <= 12; m++) begin
            logic [4:0] e_ce, e_sq;
            cyc();
            e_ce = ((m % 5 == 0) ? 5'b11101 : 5'b0) | (((m - 1) % 4 == 0) ? 5'b00010 : 5'b0);
            e_sq = (((m / 5) % 2 == 1) ? 5'b11101 : 5'b0) | ((((m + 3) / 4) % 2 == 1) ? 5'b00010 : 5'b0);
            check($sformatf("p2_ce%0d", m), 32'(bus.o_ce_div), 32'(e_ce));
            check($sformatf("p2_sq%0d", m), 32'(bus.o_sq_div), 32'(e_sq));
        end

        // Channel 2 at D=8 gets D=3 mid-period: 8-tick period completes, then 3-tick periods.
        do_reset();
        cfg(2, 8, 0);
        sync_pulse();
        bus.i_ce_mhz = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            if (t == 4) begin
                cfg(2, 3, 0);
            end else begin
                cyc();
            end
            check($sformatf("p3_ce%0d", t), 32'(bus.o_ce_div[2]), (t == 8 || t == 11 || t == 14) ? 1 : 0);
            check($sformatf("p3_pend%0d", t), 32'(bus.o_cfg_pending), (t >= 4 && t <= 7) ? 32'h04 : 0);
        end

        // Enable one cycle in three, channel 0 D=2: strobe every 6 clocks.
        do_reset();
        cfg(0, 2, 0);
        sync_pulse();
        for (int c = 1; c <= 18; c++) begin
            bus.i_ce_mhz = (c % 3 == 1);
            cyc();
            check($sformatf("p4_ce%0d", c), 32'(bus.o_ce_div),
                  32'((c == 4 || c == 10 || c == 16) ? 5'b00001 : 5'b0) | 32'((c == 13) ? 5'b11110 : 5'b0));
            check($sformatf("p4_sq%0d", c), 32'(bus.o_sq_div[0]), ((c >= 4 && c < 10) || c >= 16) ? 1 : 0);
        end

        // D=0 written: period finishes with its strobe, then the channel is silent.
        do_reset();
        cfg(3, 0, 0);
        check("p5_stop_pend", 32'(bus.o_cfg_pending), 32'h08);
        bus.i_ce_mhz = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            cyc();
            check($sformatf("p5_stop_ce%0d", t), 32'(bus.o_ce_div[3]), (t == 5) ? 1 : 0);
            check($sformatf("p5_stop_sq%0d", t), 32'(bus.o_sq_div[3]), (t == 5) ? 1 : 0);
            check($sformatf("p5_stop_pd%0d", t), 32'(bus.o_cfg_pending[3]), (t < 5) ? 1 : 0);
        end
        // D=2 while stopped: applied the next cycle, strobe two ticks later.
        cfg(3, 2, 0);
        check("p5_run_pend", 32'(bus.o_cfg_pending[3]), 1);
        for (int t = 1; t <= 4; t++) begin
            cyc();
            check($sformatf("p5_run_pd%0d", t), 32'(bus.o_cfg_pending[3]), 0);
            check($sformatf("p5_run_ce%0d", t), 32'(bus.o_ce_div[3]), (t == 3) ? 1 : 0);
        end
        // Phase 7 with D=4 clamps to 0: first strobe after the 4th tick.
        bus.i_ce_mhz = 1'b0;
        cfg(4, 4, 7);
        sync_pulse();
        bus.i_ce_mhz = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            cyc();
            check($sformatf("p5_clamp_ce%0d", t), 32'(bus.o_ce_div[4]), (t == 4) ? 1 : 0);
        end
        // Out-of-range channel index is ignored.
        bus.i_ce_mhz = 1'b0;
        cfg(5, 1, 0);
        check("p5_oor_pend", 32'(bus.o_cfg_pending), 0);
        // Second write while pending overwrites the shadow.
        cfg(0, 9, 0);
        cfg(0, 2, 0);
        check("p5_ovr_pend", 32'(bus.o_cfg_pending), 32'h01);
        sync_pulse();
        bus.i_ce_mhz = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            cyc();
            check($sformatf("p5_ovr_ce%0d", t), 32'(bus.o_ce_div[0]), (t == 2) ? 1 : 0);
        end

        // Short asynchronous reset pulse mid-period.
        do_reset();
        bus.i_ce_mhz = 1'b1;
        repeat (5) cyc();
        check("p6_pre_ce", 32'(bus.o_ce_div), 32'h1f);
        #1 rst_n = 1'b0;
        #1;
        check("p6_async_ce", 32'(bus.o_ce_div), 0);
        check("p6_async_sq", 32'(bus.o_sq_div), 0);
        #1 rst_n = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            cyc();
            check($sformatf("p6_ce%0d", n), 32'(bus.o_ce_div), (n % 5 == 0) ? 32'h1f : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
